// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready input queue.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry FIFO; otherwise a single holding register is used.
module uart_tx #(
    parameter int CLKS_PER_BIT = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          fifo_empty;
    logic [7:0]    fifo_head;
    logic          push;
    logic          pop;
    logic          tc;

    assign tc   = (timer == TW'(CLKS_PER_BIT - 1));
    assign push = tx_valid && tx_ready;
    // Pop is issued from IDLE, or at the end of STOP so the next start bit follows without a gap.
    assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && tc));

`ifdef UART_TX_FIFO_EN
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        fifo_full;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign tx_ready   = !fifo_full;
    assign fifo_count = wr_ptr - rd_ptr;
    assign fifo_head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= tx_data;
    end
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    assign fifo_empty = !hold_valid;
    assign tx_ready   = !hold_valid;
    assign fifo_count = CW'(hold_valid);
    assign fifo_head  = hold_data;

    // push needs an empty register and pop a full one, so they never coincide.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (push) begin
            hold_valid <= 1'b1;
            hold_data  <= tx_data;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    timer   <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    if (pop) begin
                        shreg   <= fifo_head;
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (tc) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shreg[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA: begin
                    if (tc) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // tx is registered, so it takes the bit that lands in position 0 after the shift.
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shreg[1];
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP: begin
                    if (tc) begin
                        timer <= '0;
                        if (pop) begin
                            shreg <= fifo_head;
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state   <= IDLE;
                            tx      <= 1'b1;
                            tx_busy <= 1'b0;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    timer   <= '0;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: timeline reference model, line decoder and scenario tasks.
module tb_uart_tx;

    localparam int CPB   = 8;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int D = 4;
`else
    localparam int D = 1;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Reference model: a frame occupies FRAME cycles from its pop edge; a pop happens on any edge
    // where the transmitter is free and something is queued.
    int         cyc = 0;
    int         m_free = 0;
    int         m_start = 0;
    int         idx;
    bit         pop_ok, push_ok;
    logic [7:0] m_cur = 8'h00;
    logic [7:0] m_q[$];
    logic       e_tx = 1'b1, e_busy = 1'b0, e_ready = 1'b1;
    int         e_count = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_free = 0;
            e_tx = 1'b1; e_busy = 1'b0; e_ready = 1'b1; e_count = 0;
        end else begin
            cyc++;
            pop_ok  = (m_q.size() > 0) && (cyc >= m_free);
            push_ok = tx_valid && (m_q.size() < D);
            if (pop_ok) begin
                m_cur   = m_q.pop_front();
                m_start = cyc;
                m_free  = cyc + FRAME;
            end
            if (push_ok) m_q.push_back(tx_data);
            e_count = m_q.size();
            e_ready = (e_count < D);
            e_busy  = (cyc < m_free);
            if (e_busy) begin
                idx = (cyc - m_start) / CPB;
                if (idx == 0)      e_tx = 1'b0;
                else if (idx == 9) e_tx = 1'b1;
                else               e_tx = m_cur[idx-1];
            end else begin
                e_tx = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            checks++;
            if ({tx, tx_busy, tx_ready} !== {e_tx, e_busy, e_ready} || fifo_count !== 3'(e_count)) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL cycle_model cyc=%0d tx/busy/ready/count got %b%b%b/%0d expected %b%b%b/%0d",
                             cyc, tx, tx_busy, tx_ready, fifo_count, e_tx, e_busy, e_ready, e_count);
            end
        end
    end

    // Line decoder acting as the receiving end: mid-bit sampling from the start edge.
    int         r_n = 0;
    bit         r_act = 1'b0;
    logic [9:0] r_bits = '0;
    logic [7:0] rx_q[$];
    int         busy_cnt = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            r_act = 1'b0;
        end else begin
            if (tx_busy === 1'b1) busy_cnt++;
            if (!r_act && tx === 1'b0) begin
                r_act = 1'b1;
                r_n   = 0;
            end
            if (r_act) begin
                if (r_n % CPB == CPB / 2) r_bits[r_n / CPB] = tx;
                r_n++;
                if (r_n == 9 * CPB + CPB / 2 + 1) begin
                    r_act = 1'b0;
                    checks++;
                    if (r_bits[0] !== 1'b0 || r_bits[9] !== 1'b1) begin
                        errors++;
                        $display("FAIL framing start/stop got %b/%b expected 0/1", r_bits[0], r_bits[9]);
                    end
                    rx_q.push_back(r_bits[8:1]);
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
            tx_data = 8'($urandom);
            @(negedge clk);
            n++;
        end
        if (n >= 4 * FRAME) begin
            errors++;
            $display("FAIL push_timeout got ready=%b expected 1", tx_ready);
        end
        tx_data = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((e_busy || e_count != 0) && n < 400 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400 * FRAME) begin
            errors++;
            $display("FAIL idle_timeout got busy=%b expected 0", tx_busy);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n  = 1'b0;
        tx_valid = 1'b0;
        #1;
        checks++;
        if ({tx, tx_busy, tx_ready} !== 3'b101 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_values got tx/busy/ready/count %b%b%b/%0d expected 101/0",
                     tx, tx_busy, tx_ready, fifo_count);
        end
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        rx_q.delete();
        busy_cnt = 0;
        push(8'h55);
        checks++;
        if (tx !== 1'b1) begin
            errors++;
            $display("FAIL single_pre_start got tx=%b expected 1", tx);
        end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0 || tx_busy !== 1'b1 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL single_latency got tx/busy/count %b%b/%0d expected 01/0", tx, tx_busy, fifo_count);
        end
        wait_idle();
        checks++;
        if (busy_cnt != FRAME) begin
            errors++;
            $display("FAIL single_busy_len got %0d expected %0d", busy_cnt, FRAME);
        end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h55) begin
            errors++;
            $display("FAIL single_data got size=%0d expected 1 byte 55", rx_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq[4];
        seq = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        rx_q.delete();
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
`ifdef UART_TX_FIFO_EN
            checks++;
            if (tx_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready byte %0d got %b expected 1", i, tx_ready);
            end
`endif
            push(seq[i]);
        end
        wait_idle();
        checks++;
        if (busy_cnt != 4 * FRAME) begin
            errors++;
            $display("FAIL b2b_busy_len got %0d expected %0d", busy_cnt, 4 * FRAME);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rx_q.size() != 4 || rx_q[i] !== seq[i]) begin
                errors++;
                $display("FAIL b2b_data byte %0d got %h expected %h", i, (rx_q.size() > i) ? rx_q[i] : 8'hxx, seq[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] sent[$];
        logic [7:0] b;
        int n;
        rx_q.delete();
        b = 8'($urandom);
        tx_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            n = 0;
            while (tx_ready !== 1'b1 && n < 4 * FRAME) begin
                if (n == 0) begin
                    checks++;
                    if (fifo_count !== 3'(D)) begin
                        errors++;
                        $display("FAIL bp_full_level got %0d expected %0d", fifo_count, D);
                    end
                end
                tx_data = 8'($urandom);
                @(negedge clk);
                n++;
            end
            tx_data = b;
            sent.push_back(b);
            b = b + 8'd1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_idle();
        checks++;
        if (rx_q.size() != sent.size()) begin
            errors++;
            $display("FAIL bp_count got %0d expected %0d", rx_q.size(), sent.size());
        end
        for (int i = 0; i < sent.size() && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== sent[i]) begin
                errors++;
                $display("FAIL bp_data byte %0d got %h expected %h", i, rx_q[i], sent[i]);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] sent[$];
        logic [7:0] b;
        int n;
        rx_q.delete();
        for (int i = 0; i <= D; i++) begin
            b = 8'($urandom);
            sent.push_back(b);
            push(b);
        end
        b = 8'($urandom);
        sent.push_back(b);
        tx_valid = 1'b1;
        tx_data  = b;
        n = 0;
        while (fifo_count === 3'(D) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (fifo_count !== 3'(D - 1)) begin
            errors++;
            $display("FAIL full_pop_edge got count=%0d expected %0d", fifo_count, D - 1);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        checks++;
        if (fifo_count !== 3'(D)) begin
            errors++;
            $display("FAIL full_pop_accept got count=%0d expected %0d", fifo_count, D);
        end
        wait_idle();
        for (int i = 0; i < sent.size(); i++) begin
            checks++;
            if (rx_q.size() != sent.size() || rx_q[i] !== sent[i]) begin
                errors++;
                $display("FAIL full_pop_data byte %0d got size %0d expected %h", i, rx_q.size(), sent[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        rx_q.delete();
        push(8'hF0);
        for (int i = 0; i < ((D < 2) ? D : 2); i++) push(8'($urandom));
        n = 0;
        while (!(e_busy && (cyc - m_start) == 4 * CPB + CPB / 2) && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({tx, tx_busy, tx_ready} !== 3'b101 || fifo_count !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid got tx/busy/ready/count %b%b%b/%0d expected 101/0",
                     tx, tx_busy, tx_ready, fifo_count);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        rx_q.delete();
        push(8'h81);
        wait_idle();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h81) begin
            errors++;
            $display("FAIL reset_mid_after got size=%0d expected 1 byte 81", rx_q.size());
        end
    endtask

    task automatic test_loopback();
        rx_q.delete();
        for (int i = 0; i < 256; i++) push(8'(i));
        wait_idle();
        checks++;
        if (rx_q.size() != 256) begin
            errors++;
            $display("FAIL loop_count got %0d expected 256", rx_q.size());
        end
        for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
            checks++;
            if (rx_q[i] !== 8'(i)) begin
                errors++;
                $display("FAIL loop_data byte %0d got %h expected %h", i, rx_q[i], 8'(i));
            end
        end
    endtask

    initial begin
        #7000000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        chk_en = 1'b1;
        test_single();
        test_back_to_back();
        test_backpressure();
        test_full_pop();
        test_reset_mid();
        test_loopback();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
